// File: rtl/i2c_slave_regfile_if.sv
// I2C bus pins seen by the register-file slave: raw SCL/SDA in, open-drain pull-down out.
interface i2c_slave_regfile_if;
   logic scl;
   logic sda_in;
   logic sda_oe;

   modport slave  (input scl, input sda_in, output sda_oe);
   modport master (output scl, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a byte-wide register file with auto-incrementing pointer,
// plus a host-side write/read port. All bus sampling is done on synchronized SCL/SDA.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NUM_REGS   = 16,
   localparam int        PTR_W      = $clog2(NUM_REGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   i2c_slave_regfile_if.slave bus,
   output logic               busy,
   output logic               wr_strobe,
   output logic [PTR_W-1:0]   wr_addr,
   output logic [7:0]         wr_data,
   input  logic               host_we,
   input  logic [PTR_W-1:0]   host_waddr,
   input  logic [7:0]         host_wdata,
   input  logic [PTR_W-1:0]   host_raddr,
   output logic [7:0]         host_rdata
);

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, ACK_ADDR, GET_PTR, ACK_PTR,
      GET_DATA, ACK_DATA, SEND_DATA, GET_MACK
   } state_t;

   logic scl_p0_q, scl_p1_q, scl_p2_q, scl_p0_d, scl_p1_d, scl_p2_d;
   logic sda_p0_q, sda_p1_q, sda_p2_q, sda_p0_d, sda_p1_d, sda_p2_d;

   state_t           state_q, state_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             rw_q, rw_d;
   logic             phase_q, phase_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       host_rdata_q, host_rdata_d;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       regs_d [NUM_REGS];

   logic             scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]       rx_byte;
   logic [PTR_W-1:0] ptr_inc;
   logic [2:0]       tx_idx;

   // ---- stage p1/p2: synchronized levels and their previous values give edges
   assign scl_rise  =  scl_p1_q & ~scl_p2_q;
   assign scl_fall  = ~scl_p1_q &  scl_p2_q;
   assign start_det =  scl_p1_q & scl_p2_q & ~sda_p1_q &  sda_p2_q;
   assign stop_det  =  scl_p1_q & scl_p2_q &  sda_p1_q & ~sda_p2_q;
   assign rx_byte   = {shreg_q[6:0], sda_p1_q};
   assign ptr_inc   = ptr_q + PTR_W'(1);
   // bit_cnt_q holds the number of bits already clocked out when SCL falls
   assign tx_idx    = 3'd7 - bit_cnt_q[2:0];

   assign bus.sda_oe = sda_oe_q;
   assign busy       = busy_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign host_rdata = host_rdata_q;

   always_comb begin
      scl_p0_d     = bus.scl;
      scl_p1_d     = scl_p0_q;
      scl_p2_d     = scl_p1_q;
      sda_p0_d     = bus.sda_in;
      sda_p1_d     = sda_p0_q;
      sda_p2_d     = sda_p1_q;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      rw_d         = rw_q;
      phase_d      = phase_q;
      ptr_d        = ptr_q;
      sda_oe_d     = sda_oe_q;
      busy_d       = busy_q;
      wr_strobe_d  = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      host_rdata_d = regs_q[host_raddr];
      regs_d       = regs_q;

      // Host write first so a same-register I2C write below overrides it
      if (host_we) regs_d[host_waddr] = host_wdata;

      if (!en) begin
         state_d   = IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
      end else if (start_det) begin
         state_d   = GET_ADDR;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: sda_oe_d = 1'b0;
            GET_ADDR, GET_PTR, GET_DATA: begin
               sda_oe_d = 1'b0;
               if (scl_rise) begin
                  shreg_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (state_q == GET_ADDR) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                           state_d = ACK_ADDR;
                           rw_d    = rx_byte[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == GET_PTR) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        state_d = ACK_PTR;
                     end else begin
                        regs_d[ptr_q] = rx_byte;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = rx_byte;
                        ptr_d         = ptr_inc;
                        state_d       = ACK_DATA;
                     end
                  end
               end
            end
            ACK_ADDR, ACK_PTR, ACK_DATA: begin
               // First SCL fall after the 8th bit starts the ACK, the next one ends it
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q != ACK_ADDR) begin
                        state_d = GET_DATA;
                     end else if (!rw_q) begin
                        state_d = GET_PTR;
                     end else begin
                        state_d  = SEND_DATA;
                        shreg_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                     end
                  end
               end
            end
            SEND_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = GET_MACK;
                  end else begin
                     sda_oe_d = ~shreg_q[tx_idx];
                  end
               end
            end
            GET_MACK: begin
               sda_oe_d = 1'b0;
               if (scl_rise) begin
                  if (!sda_p1_q) begin
                     phase_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end else if (scl_fall && phase_q) begin
                  phase_d   = 1'b0;
                  ptr_d     = ptr_inc;
                  shreg_d   = regs_q[ptr_inc];
                  sda_oe_d  = ~regs_q[ptr_inc][7];
                  bit_cnt_d = '0;
                  state_d   = SEND_DATA;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p0_q     <= 1'b1;
         scl_p1_q     <= 1'b1;
         scl_p2_q     <= 1'b1;
         sda_p0_q     <= 1'b1;
         sda_p1_q     <= 1'b1;
         sda_p2_q     <= 1'b1;
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         rw_q         <= 1'b0;
         phase_q      <= 1'b0;
         ptr_q        <= '0;
         sda_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         wr_strobe_q  <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         host_rdata_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         scl_p0_q     <= scl_p0_d;
         scl_p1_q     <= scl_p1_d;
         scl_p2_q     <= scl_p2_d;
         sda_p0_q     <= sda_p0_d;
         sda_p1_q     <= sda_p1_d;
         sda_p2_q     <= sda_p2_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         rw_q         <= rw_d;
         phase_q      <= phase_d;
         ptr_q        <= ptr_d;
         sda_oe_q     <= sda_oe_d;
         busy_q       <= busy_d;
         wr_strobe_q  <= wr_strobe_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         host_rdata_q <= host_rdata_d;
         regs_q       <= regs_d;
      end
   end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL provide parameter SLAVE_ADDR, default 7'h50: 7-bit bus address the slave responds to.
REQ-002 SHALL provide parameter NUM_REGS, default 16: register-file depth, a power of 2, range 2..256.
REQ-003 SHALL derive local parameter PTR_W = clog2(NUM_REGS), the register pointer width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk  input  1  single clock; all logic on posedge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port en  input  1  block enable; 0 forces IDLE and releases SDA.
REQ-008 Port scl  input  1  raw I2C clock from the bus.
REQ-009 Port sda_in  input  1  raw I2C data from the bus.
REQ-010 Port sda_oe  output  1  1 = drive SDA low (open drain); 0 = release.
REQ-011 Port busy  output  1  high from an address match until STOP, abort or NACK-ended read.
REQ-012 Port wr_strobe  output  1  one-cycle pulse per register written over I2C.
REQ-013 Port wr_addr  output  PTR_W  register index written; valid with wr_strobe.
REQ-014 Port wr_data  output  8  byte written; valid with wr_strobe.
REQ-015 Port host_we, host_waddr[PTR_W], host_wdata[8]  input  host-side register write port.
REQ-016 Port host_raddr  input  PTR_W  host-side read index.
REQ-017 Port host_rdata  output  8  regs[host_raddr], registered, 1-cycle latency.

Function
REQ-018 scl and sda_in SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals only.
REQ-019 START/repeated START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-020 SDA SHALL be sampled on the synced SCL rising edge; sda_oe SHALL change only in the cycle after a synced SCL falling edge.
REQ-021 The FSM SHALL use the states IDLE, GET_ADDR, ACK_ADDR, GET_PTR, ACK_PTR, GET_DATA, ACK_DATA, SEND_DATA, GET_MACK.
REQ-022 START from any state -> GET_ADDR with the bit counter cleared; STOP from any state -> IDLE; both take priority over bit activity in the same cycle.
REQ-023 GET_ADDR SHALL shift 8 bits MSB first; when addr[7:1]==SLAVE_ADDR -> ACK_ADDR (drive sda_oe=1 for one SCL period); on mismatch -> IDLE with sda_oe=0.
REQ-024 After ACK_ADDR, R/W=0 -> GET_PTR; R/W=1 -> SEND_DATA, loading regs[ptr].
REQ-025 GET_PTR SHALL receive 8 bits, load ptr from the low PTR_W bits (upper bits ignored), then ACK_PTR -> GET_DATA.
REQ-026 Each complete GET_DATA byte SHALL write regs[ptr], pulse wr_strobe with wr_addr=ptr and wr_data=byte, ACK in ACK_DATA, and increment ptr.
REQ-027 SEND_DATA SHALL drive 8 bits MSB first (sda_oe = ~bit), release SDA, then go to GET_MACK.
REQ-028 In GET_MACK, ACK (SDA=0) SHALL increment ptr, load regs[ptr] and return to SEND_DATA; NACK (SDA=1) -> IDLE.
REQ-029 ptr SHALL wrap modulo NUM_REGS (NUM_REGS-1 -> 0); ptr SHALL persist across transactions until rewritten.
REQ-030 If I2C and host writes hit the same register in the same cycle, the I2C write SHALL win; writes to different registers SHALL both complete.
REQ-031 en=0 SHALL force IDLE and sda_oe=0 in the next cycle, with register contents and ptr retained.
REQ-032 sda_oe SHALL be 0 in IDLE, GET_ADDR, GET_PTR, GET_DATA and GET_MACK.

Reset
REQ-033 On rst (sampled on posedge clk), the block SHALL set: state=IDLE, ptr=0, all regs=0, sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0, synchronizers=1 (bus idle).
REQ-034 rst asserted mid-transfer SHALL release SDA in the cycle after its assertion and discard any partial byte.

Verification
REQ-035 Write test: START, 0xA0, 0x03, 0x11, 0x22, STOP -> slave ACKs all 4 bytes; wr_strobe pulses at (3,0x11) and (4,0x22); regs[3]=0x11, regs[4]=0x22.
REQ-036 Read test: START, 0xA0, 0x03, Sr, 0xA1, master ACK then NACK -> slave sends 0x11 then 0x22, then reaches IDLE; busy falls.
REQ-037 Address mismatch: START, 0xB0 -> sda_oe stays 0 at ACK bit; no wr_strobe; busy stays 0.
REQ-038 Wrap test: NUM_REGS=16, ptr=0x0F, write 0xAA, 0xBB -> regs[15]=0xAA, regs[0]=0xBB.
REQ-039 Abort test: STOP after 4 data bits -> IDLE, no write; rst during SEND_DATA -> sda_oe=0 next cycle.
REQ-040 Collision test: host_we to reg 5 in the same cycle as an I2C write of 0x77 to reg 5 -> regs[5]=0x77; host_rdata returns 0x77 one cycle after host_raddr=5.
